// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dffsnq_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : gf180mcu_fd_sc_mcu9t5v0__dffsnq_pipe                             |
// | Purpose : WIDTH x DEPTH preset-type register pipeline with load enable,    |
// |           full-chain scan shift and a fill-tracking valid flag.            |
// | Option  : GF180_DFFSNQ_PIPE_NOTIFIER_EN adds the timing-check notifier     |
// |           input; any change on it corrupts every stage bit to X and        |
// |           clears the fill counter.                                         |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module gf180mcu_fd_sc_mcu9t5v0__dffsnq_pipe #(
  parameter int              WIDTH = 4,
  parameter int              DEPTH = 2,
  parameter logic [WIDTH-1:0] INIT = {WIDTH{1'b1}}
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             SE,
  input  logic             SI,
`ifdef GF180_DFFSNQ_PIPE_NOTIFIER_EN
  input  logic             notifier,
`endif
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             SO,
  output logic             VLD
);

  // Scan chain spans every bit of every stage; stage 0 bit 0 is the head.
  localparam int CHAIN_W = DEPTH * WIDTH;
  // Counter must be able to hold the value DEPTH itself.
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

  logic [WIDTH-1:0]   stage_q [DEPTH];
  logic [WIDTH-1:0]   stage_d [DEPTH];
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               vld_q;
  logic               vld_d;

  logic [CHAIN_W-1:0] chain_w;
  logic [CHAIN_W-1:0] chain_shift_w;

  // Flatten the stages into one vector so that a scan shift is a single
  // left shift: stage[s][WIDTH-1] naturally feeds stage[s+1][0].
  genvar gs;
  generate
    for (gs = 0; gs < DEPTH; gs++) begin : g_pack
      assign chain_w[gs*WIDTH +: WIDTH] = stage_q[gs];
    end
  endgenerate

  // A one-bit chain has nothing to shift along; SI simply replaces it.
  generate
    if (CHAIN_W == 1) begin : g_shift_single
      assign chain_shift_w = SI;
    end else begin : g_shift_multi
      assign chain_shift_w = {chain_w[CHAIN_W-2:0], SI};
    end
  endgenerate

  // Next-state selection: scan beats functional load, otherwise hold.
  always_comb begin
    for (int s = 0; s < DEPTH; s++) begin
      stage_d[s] = stage_q[s];
    end
    cnt_d = cnt_q;

    if (SE) begin
      for (int s = 0; s < DEPTH; s++) begin
        stage_d[s] = chain_shift_w[s*WIDTH +: WIDTH];
      end
      // Scanned-in contents are not functional data, so fill restarts.
      cnt_d = '0;
    end else if (EN) begin
      stage_d[0] = D;
      for (int s = 1; s < DEPTH; s++) begin
        stage_d[s] = stage_q[s-1];
      end
      // Saturate at DEPTH so VLD never drops while the pipe keeps flowing.
      cnt_d = (cnt_q == c_depth) ? cnt_q : cnt_q + c_one;
    end

    vld_d = (cnt_d == c_depth);
  end

`ifdef GF180_DFFSNQ_PIPE_NOTIFIER_EN
  logic notifier_seen_q;

  // State register with async preset plus notifier-triggered X corruption;
  // a notifier change is recognised by comparing against its last seen value.
  always_ff @(posedge CLK or posedge RST or posedge notifier or negedge notifier) begin
    notifier_seen_q <= notifier;
    if (RST) begin
      for (int s = 0; s < DEPTH; s++) begin
        stage_q[s] <= INIT;
      end
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else if (notifier != notifier_seen_q) begin
      for (int s = 0; s < DEPTH; s++) begin
        stage_q[s] <= 'x;
      end
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else begin
      for (int s = 0; s < DEPTH; s++) begin
        stage_q[s] <= stage_d[s];
      end
      cnt_q <= cnt_d;
      vld_q <= vld_d;
    end
  end
`else
  // State register with asynchronous preset to INIT.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int s = 0; s < DEPTH; s++) begin
        stage_q[s] <= INIT;
      end
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else begin
      for (int s = 0; s < DEPTH; s++) begin
        stage_q[s] <= stage_d[s];
      end
      cnt_q <= cnt_d;
      vld_q <= vld_d;
    end
  end
`endif

  assign Q   = stage_q[DEPTH-1];
  assign SO  = stage_q[DEPTH-1][WIDTH-1];
  assign VLD = vld_q;

endmodule
`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__dffsnq_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_gf180mcu_fd_sc_mcu9t5v0__dffsnq_pipe                          |
// | Purpose : Self-checking bench; directed scenarios followed by random       |
// |           traffic compared against a bit-vector model of the chain.        |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_gf180mcu_fd_sc_mcu9t5v0__dffsnq_pipe;

  localparam int W   = 4;
  localparam int DEP = 2;
  localparam logic [W-1:0] c_init = 4'hF;
  localparam int CW  = W * DEP;

  logic         clk;
  logic         rst;
  logic         en;
  logic         se;
  logic         si;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic         so;
  logic         vld;
`ifdef GF180_DFFSNQ_PIPE_NOTIFIER_EN
  logic         notifier;
`endif

  int n_cmp;
  int n_bad;

  // Reference model: whole pipeline as one integer, stage 0 in the low bits.
  logic [63:0] m_chain;
  int          m_cnt;
  logic [63:0] m_mask;

  gf180mcu_fd_sc_mcu9t5v0__dffsnq_pipe #(
    .WIDTH (W),
    .DEPTH (DEP),
    .INIT  (c_init)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .EN       (en),
    .SE       (se),
    .SI       (si),
`ifdef GF180_DFFSNQ_PIPE_NOTIFIER_EN
    .notifier (notifier),
`endif
    .D        (d),
    .Q        (q),
    .SO       (so),
    .VLD      (vld)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model_q();
    return W'((m_chain >> ((DEP - 1) * W)) & ((64'd1 << W) - 1));
  endfunction

  task automatic model_reset();
    m_chain = '0;
    for (int s = 0; s < DEP; s++) m_chain = (m_chain << W) | 64'(c_init);
    m_cnt = 0;
  endtask

  task automatic check_model(input string tag);
    logic [W-1:0] mq;
    mq = model_q();
    check_val({tag, "_q"},   32'(q),   32'(mq));
    check_val({tag, "_so"},  32'(so),  32'(mq[W-1]));
    check_val({tag, "_vld"}, 32'(vld), 32'(m_cnt == DEP));
  endtask

  // Apply one clock with the given inputs, advance the model, then check.
  task automatic step(input logic i_en, input logic i_se, input logic i_si,
                      input logic [W-1:0] i_d, input string tag);
    en = i_en; se = i_se; si = i_si; d = i_d;
    @(posedge clk);
    if (i_se) begin
      m_chain = ((m_chain << 1) | 64'(i_si)) & m_mask;
      m_cnt   = 0;
    end else if (i_en) begin
      m_chain = ((m_chain << W) | 64'(i_d)) & m_mask;
      m_cnt   = (m_cnt < DEP) ? m_cnt + 1 : DEP;
    end
    #1;
    check_model(tag);
  endtask

  // Pulse reset between clock edges and check outputs before any edge.
  task automatic mid_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_model(tag);
    check_val({tag, "_lit_q"}, 32'(q), 32'(c_init));
    check_val({tag, "_lit_vld"}, 32'(vld), 32'd0);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] scan_pat;
    n_cmp  = 0;
    n_bad  = 0;
    m_mask = (64'd1 << CW) - 1;
    rst = 1'b1; en = 1'b0; se = 1'b0; si = 1'b0; d = '0;
`ifdef GF180_DFFSNQ_PIPE_NOTIFIER_EN
    notifier = 1'b0;
`endif
    model_reset();
    #13;
    check_val("rst_q",   32'(q),   32'hF);
    check_val("rst_so",  32'(so),  32'd1);
    check_val("rst_vld", 32'(vld), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset pulse with no clock edge.
    mid_reset("areset");

    // Fill.
    step(1'b1, 1'b0, 1'b0, 4'h3, "fill1");
    check_val("fill1_vld_lit", 32'(vld), 32'd0);
    step(1'b1, 1'b0, 1'b0, 4'hA, "fill2");
    check_val("fill2_q_lit",   32'(q),   32'h3);
    check_val("fill2_vld_lit", 32'(vld), 32'd1);
    step(1'b1, 1'b0, 1'b0, 4'h7, "fill3");
    check_val("fill3_q_lit",   32'(q),   32'hA);
    check_val("fill3_vld_lit", 32'(vld), 32'd1);

    // Stall: Q must hold 4'h7 while disabled, then 4'h5 shows on next enable.
    step(1'b1, 1'b0, 1'b0, 4'h5, "stall_ld");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 4'hC, "stall_hold");
      check_val("stall_hold_lit", 32'(q), 32'h7);
    end
    step(1'b1, 1'b0, 1'b0, 4'h0, "stall_go");
    check_val("stall_go_lit", 32'(q), 32'h5);

    // Scan: clear chain, then shift 8'b1000_0000 MSB first with EN high.
    step(1'b1, 1'b0, 1'b0, 4'h0, "pre_scan1");
    step(1'b1, 1'b0, 1'b0, 4'h0, "pre_scan2");
    scan_pat = 8'b1000_0000;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, scan_pat[7-i], 4'hF, "scan");
      check_val("scan_vld_lit", 32'(vld), 32'd0);
      check_val("scan_so_lit",  32'(so),  (i == 7) ? 32'd1 : 32'd0);
    end

    // Reset mid-operation, then refill needs two captures.
    step(1'b1, 1'b0, 1'b0, 4'h6, "mop1");
    step(1'b1, 1'b0, 1'b0, 4'h6, "mop2");
    check_val("mop_q_lit",   32'(q),   32'h6);
    check_val("mop_vld_lit", 32'(vld), 32'd1);
    mid_reset("mop_rst");
    step(1'b1, 1'b0, 1'b0, 4'h1, "refill1");
    check_val("refill1_vld_lit", 32'(vld), 32'd0);
    step(1'b1, 1'b0, 1'b0, 4'h2, "refill2");
    check_val("refill2_vld_lit", 32'(vld), 32'd1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 1)), 4'($urandom), "rand");
      if ($urandom_range(0, 39) == 0) mid_reset("rand_rst");
    end

`ifdef GF180_DFFSNQ_PIPE_NOTIFIER_EN
    // Notifier corruption, then reset restores the preset word.
    #2;
    notifier = ~notifier;
    #1;
    check_val("notif_vld", 32'(vld), 32'd0);
    mid_reset("notif_rst");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
